// File: rtl/wb_stage_reg_multi_pkg.sv
// Shared definitions for the multi-lane MEM/WB pipeline register:
// legacy control constants, bus widths and the bubble records loaded
// on flush or when the upstream stage stalls into a running downstream.
package wb_stage_reg_multi_pkg;

   localparam logic       RstEnable     = 1'b1;
   localparam logic       Stop          = 1'b1;
   localparam logic       NoStop        = 1'b0;
   localparam logic       WriteDisable  = 1'b0;
   localparam int         RegBusWidth     = 32;
   localparam int         RegAddrBusWidth = 5;
   localparam logic [RegBusWidth-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBusWidth-1:0] NOPRegAddr = '0;

   // Per-lane writeback record
   typedef struct packed {
      logic                       valid;
      logic [RegAddrBusWidth-1:0] wd;
      logic                       wreg;
      logic [RegBusWidth-1:0]     wdata;
      logic [RegBusWidth-1:0]     pc;
   } lane_fields_t;

   // Fields owned by lane 0 only (HI/LO and CP0 writes)
   typedef struct packed {
      logic                       whilo;
      logic [RegBusWidth-1:0]     hi;
      logic [RegBusWidth-1:0]     lo;
      logic                       cp0_we;
      logic [RegAddrBusWidth-1:0] cp0_addr;
      logic [RegBusWidth-1:0]     cp0_data;
   } shared_fields_t;

   localparam lane_fields_t BUBBLE = '{
      valid: WriteDisable, wd: NOPRegAddr, wreg: WriteDisable,
      wdata: ZeroWord, pc: ZeroWord};

   localparam shared_fields_t SHARED_BUBBLE = '{
      whilo: WriteDisable, hi: ZeroWord, lo: ZeroWord,
      cp0_we: WriteDisable, cp0_addr: NOPRegAddr, cp0_data: ZeroWord};

endpackage

// File: rtl/wb_stage_reg_multi_wb_lane_arbiter.sv
// Combinational same-destination arbiter: when an older and a younger lane
// both write the same register, only the younger (higher index) keeps its
// write enable. Lane data is unaffected; only enables are cleared.
module wb_lane_arbiter
   import wb_stage_reg_multi_pkg::*;
#(
   parameter int LANES = 2
) (
   input  logic [LANES-1:0]                 wreg_in,
   input  logic [RegAddrBusWidth*LANES-1:0] wd_in,
   output logic [LANES-1:0]                 wreg_out
);

   generate
      if (LANES == 1) begin : g_single
         // A single lane has nobody to collide with
         assign wreg_out = wreg_in;
      end else begin : g_multi
         // Clear an older lane's enable if any younger lane writes the same register
         always_comb begin
            wreg_out = wreg_in;
            for (int i = 0; i < LANES - 1; i++) begin
               for (int j = i + 1; j < LANES; j++) begin
                  if (wreg_in[i] && wreg_in[j] &&
                      wd_in[RegAddrBusWidth*i +: RegAddrBusWidth] ==
                      wd_in[RegAddrBusWidth*j +: RegAddrBusWidth]) begin
                     wreg_out[i] = 1'b0;
                  end
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/wb_stage_reg_multi.sv
// Multi-lane MEM/WB pipeline register with flush, bubble insertion,
// same-destination lane arbitration and a retired-instruction counter.
// Optional macro WB_DEBUG_TRACE_EN adds combinational trace outputs.
module wb_stage_reg_multi
   import wb_stage_reg_multi_pkg::*;
#(
   parameter int LANES = 2,
   parameter int STAGE = 4,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5:0]              stall,
   input  logic                    flush,
   input  logic [LANES-1:0]        mem_valid,
   input  logic [5*LANES-1:0]      mem_wd,
   input  logic [LANES-1:0]        mem_wreg,
   input  logic [32*LANES-1:0]     mem_wdata,
   input  logic [32*LANES-1:0]     mem_pc,
   input  logic                    mem_whilo,
   input  logic [31:0]             mem_hi,
   input  logic [31:0]             mem_lo,
   input  logic                    mem_cp0_reg_we,
   input  logic [4:0]              mem_cp0_reg_write_addr,
   input  logic [31:0]             mem_cp0_reg_data,
   output logic [LANES-1:0]        wb_valid,
   output logic [5*LANES-1:0]      wb_wd,
   output logic [LANES-1:0]        wb_wreg,
   output logic [32*LANES-1:0]     wb_wdata,
   output logic [32*LANES-1:0]     wb_pc,
   output logic                    wb_whilo,
   output logic [31:0]             wb_hi,
   output logic [31:0]             wb_lo,
   output logic                    wb_cp0_reg_we,
   output logic [4:0]              wb_cp0_reg_write_addr,
   output logic [31:0]             wb_cp0_reg_data,
   output logic [CNT_W-1:0]        retire_cnt
`ifdef WB_DEBUG_TRACE_EN
   ,
   output logic [32*LANES-1:0]     debug_wb_pc,
   output logic [4*LANES-1:0]      debug_wb_rf_wen,
   output logic [5*LANES-1:0]      debug_wb_rf_wnum,
   output logic [32*LANES-1:0]     debug_wb_rf_wdata
`endif
);

   lane_fields_t [LANES-1:0] lane_q, lane_d;
   shared_fields_t           shared_q, shared_d;
   logic [CNT_W-1:0]         retire_cnt_q, retire_cnt_d;
   logic [LANES-1:0]         wreg_masked, wreg_arb;
   logic [CNT_W-1:0]         valid_count;
   logic                     do_bubble, do_capture;

   // Decode stall/flush: flush outranks everything, then bubble, then capture
   always_comb begin
      do_bubble  = flush || (stall[STAGE] == Stop && stall[STAGE+1] == NoStop);
      do_capture = !flush && (stall[STAGE] == NoStop);
   end

   // Mask write enables by lane validity and count the incoming valid lanes
   always_comb begin
      wreg_masked = '0;
      valid_count = '0;
      for (int i = 0; i < LANES; i++) begin
         wreg_masked[i] = mem_wreg[i] & mem_valid[i];
         valid_count    = valid_count + CNT_W'(mem_valid[i]);
      end
   end

   wb_lane_arbiter #(.LANES(LANES)) u_arbiter (
      .wreg_in  (wreg_masked),
      .wd_in    (mem_wd),
      .wreg_out (wreg_arb)
   );

   // Next-state selection: bubble, capture, or hold by default
   always_comb begin
      lane_d       = lane_q;
      shared_d     = shared_q;
      retire_cnt_d = retire_cnt_q;
      if (do_bubble) begin
         for (int i = 0; i < LANES; i++) lane_d[i] = BUBBLE;
         shared_d = SHARED_BUBBLE;
      end else if (do_capture) begin
         for (int i = 0; i < LANES; i++) begin
            lane_d[i].valid = mem_valid[i];
            lane_d[i].wd    = mem_wd[5*i +: 5];
            lane_d[i].wreg  = wreg_arb[i];
            lane_d[i].wdata = mem_wdata[32*i +: 32];
            lane_d[i].pc    = mem_pc[32*i +: 32];
         end
         shared_d.whilo    = mem_whilo & mem_valid[0];
         shared_d.hi       = mem_hi;
         shared_d.lo       = mem_lo;
         shared_d.cp0_we   = mem_cp0_reg_we & mem_valid[0];
         shared_d.cp0_addr = mem_cp0_reg_write_addr;
         shared_d.cp0_data = mem_cp0_reg_data;
         retire_cnt_d      = retire_cnt_q + valid_count;
      end
   end

   // State register with synchronous reset clearing every field and the counter
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < LANES; i++) lane_q[i] <= BUBBLE;
         shared_q     <= SHARED_BUBBLE;
         retire_cnt_q <= '0;
      end else begin
         lane_q       <= lane_d;
         shared_q     <= shared_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Unpack the lane records onto the flat output buses
   always_comb begin
      wb_valid = '0;
      wb_wd    = '0;
      wb_wreg  = '0;
      wb_wdata = '0;
      wb_pc    = '0;
      for (int i = 0; i < LANES; i++) begin
         wb_valid[i]          = lane_q[i].valid;
         wb_wd[5*i +: 5]      = lane_q[i].wd;
         wb_wreg[i]           = lane_q[i].wreg;
         wb_wdata[32*i +: 32] = lane_q[i].wdata;
         wb_pc[32*i +: 32]    = lane_q[i].pc;
      end
   end

   assign wb_whilo              = shared_q.whilo;
   assign wb_hi                 = shared_q.hi;
   assign wb_lo                 = shared_q.lo;
   assign wb_cp0_reg_we         = shared_q.cp0_we;
   assign wb_cp0_reg_write_addr = shared_q.cp0_addr;
   assign wb_cp0_reg_data       = shared_q.cp0_data;
   assign retire_cnt            = retire_cnt_q;

`ifdef WB_DEBUG_TRACE_EN
   // Trace comparator view derived from the registered writeback fields
   always_comb begin
      debug_wb_pc       = wb_pc;
      debug_wb_rf_wnum  = wb_wd;
      debug_wb_rf_wdata = wb_wdata;
      debug_wb_rf_wen   = '0;
      for (int i = 0; i < LANES; i++) begin
         debug_wb_rf_wen[4*i +: 4] = {4{wb_wreg[i]}};
      end
   end
`endif

endmodule

// File: doc/wb_stage_reg_multi.md
Name: wb_stage_reg_multi

Overview:
- Parametrised MEM/WB pipeline register; successor to the single-issue MEM/WB latch.
- Sits between the memory-access stage and regfile/HILO/CP0 writeback.
- Supports LANES issue lanes with per-lane valid bits, a flush input, same-destination write arbitration between lanes, and a retired-instruction counter.
- Stall/bubble semantics follow the core's 6-bit stall vector convention.

Parameters:
- LANES, 2, number of issue lanes (1..4); lane 0 is oldest.
- STAGE, 4, index of this stage's bit in the stall vector; STAGE+1 is the downstream bit.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- stall  in  6  pipeline stall vector; bit=1 means stop
- flush  in  1  exception/ERET flush; turn this stage's next output into a bubble
- mem_valid  in  LANES  per-lane instruction valid
- mem_wd  in  5*LANES  per-lane destination register, packed, lane i at [5i+4:5i]
- mem_wreg  in  LANES  per-lane regfile write enable
- mem_wdata  in  32*LANES  per-lane write data
- mem_pc  in  32*LANES  per-lane PC
- mem_whilo  in  1  HI/LO write enable, lane 0 only
- mem_hi, mem_lo  in  32 each  HI/LO data
- mem_cp0_reg_we  in  1  CP0 write enable, lane 0 only
- mem_cp0_reg_write_addr  in  5  CP0 address
- mem_cp0_reg_data  in  32  CP0 data
- wb_valid, wb_wd, wb_wreg, wb_wdata, wb_pc  out  widths as inputs  registered lane fields
- wb_whilo, wb_hi, wb_lo, wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data  out  as inputs  registered shared fields
- retire_cnt  out  CNT_W  count of retired valid lanes

Behaviour:
- All outputs are registered and update on the posedge of clk. Latency is 1 cycle.
- Priority order each cycle: rst > flush > bubble > capture > hold.
- rst=1: every output is 0, including retire_cnt. This holds regardless of stall or flush.
- flush=1 (rst=0): load a bubble regardless of stall.
  - Bubble: all valid/wreg/whilo/cp0_we = 0; wd, data, pc, addr fields = 0.
  - retire_cnt does not change.
- Bubble condition: stall[STAGE]=1 and stall[STAGE+1]=0. Load a bubble; retire_cnt unchanged.
- Capture condition: stall[STAGE]=0. Load the inputs with these rules:
  - Valid masking: wb_wreg[i] = mem_wreg[i] & mem_valid[i].
  - whilo and cp0_we are masked by mem_valid[0].
  - Lane arbitration: if lanes i<j both have masked wreg=1 and equal wd, clear lane i's wb_wreg. The youngest writer wins; lane i's data is still registered.
  - wd=0 with wreg=1 passes through unchanged; the regfile ignores $0.
  - retire_cnt += popcount(mem_valid). Arithmetic is modulo 2^CNT_W, so it wraps silently.
- Hold condition: stall[STAGE]=1 and stall[STAGE+1]=1. All outputs keep their values; no counting.
- Bubble and flush never increment the counter, so a held instruction is counted once only.
- LANES=1: arbitration logic is absent; behaviour equals the legacy MEM/WB register plus the valid bit and counter.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- Defined: add outputs debug_wb_pc (32*LANES), debug_wb_rf_wen (4*LANES), debug_wb_rf_wnum (5*LANES), debug_wb_rf_wdata (32*LANES).
  - debug_wb_pc = wb_pc.
  - debug_wb_rf_wen[i] = {4{wb_wreg[i]}}.
  - wnum and wdata mirror wb_wd and wb_wdata.
  - All are combinational from the registered outputs, for the trace comparator.
- Undefined: these ports do not exist. wb_pc is still present but may be trimmed by synthesis.

Decomposition:
- Shared package/defines: RstEnable, Stop/NoStop, ZeroWord, NOPRegAddr, WriteDisable, the RegBus/RegAddrBus widths, and a BUBBLE constant for the lane field record.
- One sub-module, wb_lane_arbiter: purely combinational. Inputs are masked wreg and wd vectors; output is the final wreg vector. The top level holds all state.

Test Plan:
- Reset mid-stream: inputs valid=2'b11, rst=1 for one cycle with stall=0 → next cycle all outputs 0 and retire_cnt=0.
- Capture, LANES=2, stall=0: lane0 wd=3, data=0x11; lane1 wd=5, data=0x22; both valid+wreg → next cycle wb_wreg=2'b11, wd {5,3}, data {0x22,0x11}, retire_cnt=2.
- Same-destination: both lanes wd=7, wreg=1, valid=1 → wb_wreg=2'b10, wb_wdata lane1 correct, retire_cnt +2.
- stall=6'b011111 (STAGE=4 stopped, 5 running) with valid inputs → outputs bubble, retire_cnt unchanged. Then stall=6'b111111 for 3 cycles → outputs frozen at bubble.
- Hold then release: capture lane0 (valid=1, pc=0xBFC00000), then stall=6'b111111 ×2 → outputs held and retire_cnt=1 throughout. Release with valid=0 inputs → bubble captured, count still 1.
- Flush beats stall: flush=1 with stall=6'b000000 and valid inputs → bubble, count unchanged. Counter wrap with CNT_W=4: preload to 15, capture valid=2'b01 → retire_cnt=0.
